// File: rtl/jelly2_texture_bilinear_ar_gen.sv
`default_nettype none
// ============================================================================
//  Module      : jelly2_texture_bilinear_ar_gen
//  Description : Splits one signed fixed-point texel coordinate into the four
//                bilinear-neighbour read requests for the texture cache AR
//                channel, with per-corner clamp/blank border handling.
//                Optional macro JELLY2_TEXTURE_BILINEAR_SKIP_ZERO_EN skips
//                corners whose bilinear weight is zero.
//  Revision    : 1.0  initial release
// ============================================================================
module jelly2_texture_bilinear_ar_gen #(
   parameter  int S_USER_WIDTH = 1,
   parameter  int X_INT_WIDTH  = 13,
   parameter  int Y_INT_WIDTH  = 13,
   parameter  int FRAC_WIDTH   = 4,
   parameter  int ADDR_X_WIDTH = 12,
   parameter  int ADDR_Y_WIDTH = 12,
   localparam int M_USER_WIDTH = S_USER_WIDTH + 2*FRAC_WIDTH + 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ADDR_X_WIDTH-1:0]       param_width,
   input  logic [ADDR_Y_WIDTH-1:0]       param_height,
   input  logic                          param_clamp,
   input  logic [S_USER_WIDTH-1:0]       s_user,
   input  logic [X_INT_WIDTH+FRAC_WIDTH-1:0] s_x,
   input  logic [Y_INT_WIDTH+FRAC_WIDTH-1:0] s_y,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [M_USER_WIDTH-1:0]       m_aruser,
   output logic [ADDR_X_WIDTH-1:0]       m_araddrx,
   output logic [ADDR_Y_WIDTH-1:0]       m_araddry,
   output logic                          m_arstrb,
   output logic                          m_arvalid,
   input  logic                          m_arready,
   output logic                          busy
);

   // one extra bit so that x0+1 / y0+1 can never wrap
   localparam int C_XE_WIDTH = X_INT_WIDTH + 1;
   localparam int C_YE_WIDTH = Y_INT_WIDTH + 1;
   localparam logic [C_XE_WIDTH-1:0]   C_XE_ONE = {{(C_XE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [C_YE_WIDTH-1:0]   C_YE_ONE = {{(C_YE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_X_WIDTH-1:0] C_AX_ONE = {{(ADDR_X_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_Y_WIDTH-1:0] C_AY_ONE = {{(ADDR_Y_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

   state_t                   r_state;
   state_t                   w_state_next;
   logic [1:0]               r_corner;
   logic [C_XE_WIDTH-1:0]    r_x0;
   logic [C_YE_WIDTH-1:0]    r_y0;
   logic [FRAC_WIDTH-1:0]    r_fracx;
   logic [FRAC_WIDTH-1:0]    r_fracy;
   logic [S_USER_WIDTH-1:0]  r_user;
   logic [ADDR_X_WIDTH-1:0]  r_width;
   logic [ADDR_Y_WIDTH-1:0]  r_height;
   logic                     r_clamp;

   logic                     w_accept;
   logic                     w_handshake;
   logic                     w_last;
   logic [1:0]               w_final_corner;
   logic [1:0]               w_corner_next;

   assign w_accept    = s_valid && s_ready;
   assign w_handshake = (r_state == ST_ISSUE) && m_arready;

`ifdef JELLY2_TEXTURE_BILINEAR_SKIP_ZERO_EN
   // zero fraction means the +1 neighbour has zero weight; never fetch it
   logic w_skipx;
   logic w_skipy;
   assign w_skipx        = (r_fracx == '0);
   assign w_skipy        = (r_fracy == '0);
   assign w_final_corner = {!w_skipy, !w_skipx};
   assign w_corner_next  = w_skipx ? (r_corner + 2'd2) : (r_corner + 2'd1);
`else
   assign w_final_corner = 2'd3;
   assign w_corner_next  = r_corner + 2'd1;
`endif

   assign w_last  = (r_corner == w_final_corner);
   // final beat handshake frees the slot in the same cycle: no bubble
   assign s_ready = (r_state == ST_IDLE) || (w_last && m_arready);

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // next-state decode
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_next = ST_ISSUE;
         ST_ISSUE: if (w_handshake && w_last && !w_accept) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // transaction capture and corner advance
   always_ff @(posedge clk) begin
      if (reset) begin
         r_corner <= '0;
         r_x0     <= '0;
         r_y0     <= '0;
         r_fracx  <= '0;
         r_fracy  <= '0;
         r_user   <= '0;
         r_width  <= '0;
         r_height <= '0;
         r_clamp  <= 1'b0;
      end else if (w_accept) begin
         r_corner <= '0;
         // taking the integer field of a two's complement value is an exact floor
         r_x0     <= {s_x[X_INT_WIDTH+FRAC_WIDTH-1], s_x[X_INT_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH]};
         r_y0     <= {s_y[Y_INT_WIDTH+FRAC_WIDTH-1], s_y[Y_INT_WIDTH+FRAC_WIDTH-1:FRAC_WIDTH]};
         r_fracx  <= s_x[FRAC_WIDTH-1:0];
         r_fracy  <= s_y[FRAC_WIDTH-1:0];
         r_user   <= s_user;
         r_width  <= param_width;
         r_height <= param_height;
         r_clamp  <= param_clamp;
      end else if (w_handshake) begin
         r_corner <= w_last ? 2'd0 : w_corner_next;
      end
   end

   logic [C_XE_WIDTH-1:0]   w_cx;
   logic [C_YE_WIDTH-1:0]   w_cy;
   logic [C_XE_WIDTH-1:0]   w_width_ext;
   logic [C_YE_WIDTH-1:0]   w_height_ext;
   logic                    w_x_neg, w_x_hi, w_y_neg, w_y_hi;
   logic                    w_in_range;
   logic                    w_size_ok;
   logic                    w_strb;
   logic [ADDR_X_WIDTH-1:0] w_addrx_clamp;
   logic [ADDR_Y_WIDTH-1:0] w_addry_clamp;

   // corner coordinate selection and bound check; outputs derive only from
   // registers so they stay frozen while the cache stalls
   always_comb begin
      w_cx          = r_corner[0] ? (r_x0 + C_XE_ONE) : r_x0;
      w_cy          = r_corner[1] ? (r_y0 + C_YE_ONE) : r_y0;
      w_width_ext   = {{(C_XE_WIDTH-ADDR_X_WIDTH){1'b0}}, r_width};
      w_height_ext  = {{(C_YE_WIDTH-ADDR_Y_WIDTH){1'b0}}, r_height};
      w_x_neg       = w_cx[C_XE_WIDTH-1];
      w_y_neg       = w_cy[C_YE_WIDTH-1];
      w_x_hi        = !w_x_neg && (w_cx >= w_width_ext);
      w_y_hi        = !w_y_neg && (w_cy >= w_height_ext);
      w_in_range    = !w_x_neg && !w_x_hi && !w_y_neg && !w_y_hi;
      w_size_ok     = (r_width != '0) && (r_height != '0);
      w_strb        = w_size_ok && (r_clamp || w_in_range);
      w_addrx_clamp = w_x_neg ? '0 : (w_x_hi ? (r_width  - C_AX_ONE) : w_cx[ADDR_X_WIDTH-1:0]);
      w_addry_clamp = w_y_neg ? '0 : (w_y_hi ? (r_height - C_AY_ONE) : w_cy[ADDR_Y_WIDTH-1:0]);
   end

   assign m_arvalid = (r_state == ST_ISSUE);
   assign busy      = (r_state == ST_ISSUE);
   assign m_arstrb  = w_strb;
   // blank corners and clamped corners inside range both reduce to these two cases
   assign m_araddrx = !w_strb ? '0 : (r_clamp ? w_addrx_clamp : w_cx[ADDR_X_WIDTH-1:0]);
   assign m_araddry = !w_strb ? '0 : (r_clamp ? w_addry_clamp : w_cy[ADDR_Y_WIDTH-1:0]);
   assign m_aruser  = {r_user, r_fracx, r_fracy, (w_last && busy), r_corner};

endmodule
`default_nettype wire

// File: tb/tb_jelly2_texture_bilinear_ar_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jelly2_texture_bilinear_ar_gen
//  Description : Directed self-checking bench for the bilinear AR generator.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jelly2_texture_bilinear_ar_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] param_width;
   logic [11:0] param_height;
   logic        param_clamp;
   logic [0:0]  s_user;
   logic [16:0] s_x;
   logic [16:0] s_y;
   logic        s_valid;
   logic        s_ready;
   logic [11:0] m_aruser;
   logic [11:0] m_araddrx;
   logic [11:0] m_araddry;
   logic        m_arstrb;
   logic        m_arvalid;
   logic        m_arready;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   int hs_cnt   = 0;
   logic hs_clr = 1'b0;

   jelly2_texture_bilinear_ar_gen dut (
      .clk          (clk),
      .reset        (reset),
      .param_width  (param_width),
      .param_height (param_height),
      .param_clamp  (param_clamp),
      .s_user       (s_user),
      .s_x          (s_x),
      .s_y          (s_y),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .m_aruser     (m_aruser),
      .m_araddrx    (m_araddrx),
      .m_araddry    (m_araddry),
      .m_arstrb     (m_arstrb),
      .m_arvalid    (m_arvalid),
      .m_arready    (m_arready),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // count AR handshakes at the active edge
   always @(posedge clk) begin
      if (hs_clr) hs_cnt = 0;
      else if (m_arvalid && m_arready) hs_cnt = hs_cnt + 1;
   end

   typedef struct {
      logic [16:0]      x;
      logic [16:0]      y;
      logic             clamp;
      logic [11:0]      w;
      logic [11:0]      h;
      logic [3:0][11:0] ax;    // {corner3, corner2, corner1, corner0}
      logic [3:0][11:0] ay;
      logic [3:0]       strb;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] exp_user(input logic u, input logic [16:0] x,
                                            input logic [16:0] y, input logic last,
                                            input logic [1:0] c);
      return {u, x[3:0], y[3:0], last, c};
   endfunction

   task automatic chk_beat(input int i, input int k, input logic u, input logic last,
                           input logic sready);
      chk("arvalid", {31'd0, m_arvalid}, 1);
      chk("busy",    {31'd0, busy}, 1);
      chk("addrx",   {20'd0, m_araddrx}, {20'd0, vecs[i].ax[k]});
      chk("addry",   {20'd0, m_araddry}, {20'd0, vecs[i].ay[k]});
      chk("strb",    {31'd0, m_arstrb}, {31'd0, vecs[i].strb[k]});
      chk("aruser",  {20'd0, m_aruser},
          {20'd0, exp_user(u, vecs[i].x, vecs[i].y, last, 2'(k))});
      chk("s_ready", {31'd0, s_ready}, {31'd0, sready});
   endtask

   task automatic start_txn(input int i, input logic u);
      s_x          = vecs[i].x;
      s_y          = vecs[i].y;
      param_clamp  = vecs[i].clamp;
      param_width  = vecs[i].w;
      param_height = vecs[i].h;
      s_user       = u;
      s_valid      = 1'b1;
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, "_arvalid"}, {31'd0, m_arvalid}, 0);
      chk({nm, "_busy"},    {31'd0, busy}, 0);
      chk({nm, "_s_ready"}, {31'd0, s_ready}, 1);
   endtask

   initial begin
      // corners listed {c3, c2, c1, c0}
      vecs[0] = '{17'h00028, 17'h00018, 1'b0, 12'd16, 12'd16,
                  {12'd3, 12'd2, 12'd3, 12'd2}, {12'd2, 12'd2, 12'd1, 12'd1}, 4'b1111};
      vecs[1] = '{17'h1FFF8, 17'h00010, 1'b0, 12'd16, 12'd16,
                  {12'd0, 12'd0, 12'd0, 12'd0}, {12'd2, 12'd0, 12'd1, 12'd0}, 4'b1010};
      vecs[2] = '{17'h1FFF8, 17'h00010, 1'b1, 12'd16, 12'd16,
                  {12'd0, 12'd0, 12'd0, 12'd0}, {12'd2, 12'd2, 12'd1, 12'd1}, 4'b1111};
      vecs[3] = '{17'h000F8, 17'h00010, 1'b1, 12'd16, 12'd16,
                  {12'd15, 12'd15, 12'd15, 12'd15}, {12'd2, 12'd2, 12'd1, 12'd1}, 4'b1111};
      vecs[4] = '{17'h000F8, 17'h00010, 1'b0, 12'd16, 12'd16,
                  {12'd0, 12'd15, 12'd0, 12'd15}, {12'd0, 12'd2, 12'd0, 12'd1}, 4'b0101};
      vecs[5] = '{17'h00028, 17'h00018, 1'b1, 12'd0, 12'd16,
                  {12'd0, 12'd0, 12'd0, 12'd0}, {12'd0, 12'd0, 12'd0, 12'd0}, 4'b0000};
      vecs[6] = '{17'h00028, 17'h000F8, 1'b0, 12'd16, 12'd16,
                  {12'd0, 12'd0, 12'd3, 12'd2}, {12'd0, 12'd0, 12'd15, 12'd15}, 4'b0011};
      vecs[7] = '{17'h00028, 17'h1FFE8, 1'b1, 12'd16, 12'd16,
                  {12'd3, 12'd2, 12'd3, 12'd2}, {12'd0, 12'd0, 12'd0, 12'd0}, 4'b1111};

      reset = 1'b1; s_valid = 1'b0; s_user = '0; s_x = '0; s_y = '0;
      param_width = '0; param_height = '0; param_clamp = 1'b0; m_arready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk_idle("reset");
      chk("reset_addrx",  {20'd0, m_araddrx}, 0);
      chk("reset_addry",  {20'd0, m_araddry}, 0);
      chk("reset_aruser", {20'd0, m_aruser}, 0);
      chk("reset_strb",   {31'd0, m_arstrb}, 0);

`ifdef JELLY2_TEXTURE_BILINEAR_SKIP_ZERO_EN
      // x=3.0 y=2.5: corners 0 and 2 only
      @(negedge clk);
      s_x = 17'h00030; s_y = 17'h00028; param_width = 12'd16; param_height = 12'd16;
      param_clamp = 1'b0; s_user = 1'b1; s_valid = 1'b1;
      @(negedge clk); s_valid = 1'b0; #1;
      chk("skip_a0_addr", {8'd0, m_araddrx, m_araddry}, {8'd0, 12'd3, 12'd2});
      chk("skip_a0_user", {20'd0, m_aruser}, {20'd0, 1'b1, 4'd0, 4'd8, 1'b0, 2'd0});
      chk("skip_a0_rdy",  {31'd0, s_ready}, 0);
      @(negedge clk); #1;
      chk("skip_a1_addr", {8'd0, m_araddrx, m_araddry}, {8'd0, 12'd3, 12'd3});
      chk("skip_a1_user", {20'd0, m_aruser}, {20'd0, 1'b1, 4'd0, 4'd8, 1'b1, 2'd2});
      chk("skip_a1_rdy",  {31'd0, s_ready}, 1);
      @(negedge clk); #1;
      chk_idle("skip_a_end");
      // x=3.0 y=2.0: single beat
      s_x = 17'h00030; s_y = 17'h00020; s_user = 1'b0; s_valid = 1'b1;
      @(negedge clk); s_valid = 1'b0; #1;
      chk("skip_b0_addr", {8'd0, m_araddrx, m_araddry}, {8'd0, 12'd3, 12'd2});
      chk("skip_b0_user", {20'd0, m_aruser}, {20'd0, 1'b0, 4'd0, 4'd0, 1'b1, 2'd0});
      chk("skip_b0_rdy",  {31'd0, s_ready}, 1);
      @(negedge clk); #1;
      chk_idle("skip_b_end");
`else
      // table-driven single transactions, m_arready held high
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start_txn(i, 1'(i));
         #1 chk("idle_ready", {31'd0, s_ready}, 1);
         @(negedge clk);
         s_valid = 1'b0;
         #1 chk_beat(i, 0, 1'(i), 1'b0, 1'b0);
         for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1 chk_beat(i, k, 1'(i), (k == 3), (k == 3));
         end
         @(negedge clk);
         #1 chk_idle("vec_end");
      end

      // backpressure: two stall cycles on corner 1
      hs_clr = 1'b1;
      @(negedge clk);
      hs_clr = 1'b0;
      start_txn(0, 1'b1);
      @(negedge clk); s_valid = 1'b0;
      #1 chk_beat(0, 0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      m_arready = 1'b0;
      #1 chk_beat(0, 1, 1'b1, 1'b0, 1'b0);
      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         #1 chk_beat(0, 1, 1'b1, 1'b0, 1'b0);
      end
      m_arready = 1'b1;
      @(negedge clk);
      #1 chk_beat(0, 2, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk_beat(0, 3, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      #1 chk_idle("bp_end");
      chk("bp_handshakes", hs_cnt, 4);

      // back-to-back: three transactions, twelve beats, no bubble
      for (int run = 0; run < 2; run++) begin
         logic [16:0] xs [3];
         xs[0] = 17'h00028; xs[1] = 17'h00048; xs[2] = 17'h00068;
         hs_clr = 1'b1;
         @(negedge clk);
         hs_clr = 1'b0;
         param_width = 12'd16; param_height = 12'd16; param_clamp = 1'b0;
         s_y = 17'h00018; s_x = xs[0]; s_user = 1'b0; s_valid = 1'b1;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            chk("b2b_arvalid", {31'd0, m_arvalid}, 1);
            chk("b2b_corner",  {30'd0, m_aruser[1:0]}, k % 4);
            chk("b2b_addrx",   {20'd0, m_araddrx}, 2 + 2*(k/4) + (k % 2));
            chk("b2b_addry",   {20'd0, m_araddry}, 1 + (k % 4)/2);
            if (k % 4 == 3) begin
               chk("b2b_s_ready", {31'd0, s_ready}, 1);
               if (k/4 < 2) s_x = xs[k/4 + 1];
               else         s_valid = 1'b0;
            end
            if (run == 1 && k == 5) begin
               reset = 1'b1;
               s_valid = 1'b0;
               break;
            end
         end
         @(negedge clk);
         #1;
         chk("b2b_end_arvalid", {31'd0, m_arvalid}, 0);
         chk("b2b_end_busy",    {31'd0, busy}, 0);
         if (run == 0) chk("b2b_handshakes", hs_cnt, 12);
         else begin
            chk("rst_aruser", {20'd0, m_aruser}, 0);
            reset = 1'b0;
            @(negedge clk);
            #1 chk_idle("after_rst");
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jelly2_texture_bilinear_ar_gen.md
Name: jelly2_texture_bilinear_ar_gen

Overview:
- Upstream stage of the texture cache unit.
- Accepts one signed fixed-point texel coordinate per transaction and issues the four bilinear-neighbour read requests into the cache's s_ar channel, one per beat.
- Each beat carries in aruser the original user bits, the fractional weights and a corner index, so the downstream bilinear blender can weight the returned s_r data.
- Resolves border handling per corner: clamp the address, or request blank (arstrb=0).

Parameters:
- S_USER_WIDTH, 1, pass-through user width.
- X_INT_WIDTH, 13, signed integer bits of the x coordinate; must be >= ADDR_X_WIDTH+1.
- Y_INT_WIDTH, 13, signed integer bits of the y coordinate; must be >= ADDR_Y_WIDTH+1.
- FRAC_WIDTH, 4, fractional bits, shared by x and y.
- ADDR_X_WIDTH, 12, output x address width; matches the cache.
- ADDR_Y_WIDTH, 12, output y address width; matches the cache.
- M_USER_WIDTH, S_USER_WIDTH+2*FRAC_WIDTH+3, localparam; layout is {user, fracx, fracy, last, corner[1:0]}.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- param_width  in  ADDR_X_WIDTH  texture width in texels.
- param_height  in  ADDR_Y_WIDTH  texture height in texels.
- param_clamp  in  1  0: out-of-range corner issues arstrb=0 (blank); 1: coordinate clamped to the edge, arstrb=1.
- s_user  in  S_USER_WIDTH  transaction user bits.
- s_x  in  X_INT_WIDTH+FRAC_WIDTH  signed fixed-point x.
- s_y  in  Y_INT_WIDTH+FRAC_WIDTH  signed fixed-point y.
- s_valid  in  1  request valid.
- s_ready  out  1  request accept.
- m_aruser  out  M_USER_WIDTH  to cache s_aruser.
- m_araddrx  out  ADDR_X_WIDTH  to cache s_araddrx.
- m_araddry  out  ADDR_Y_WIDTH  to cache s_araddry.
- m_arstrb  out  1  to cache s_arstrb.
- m_arvalid  out  1  to cache s_arvalid.
- m_arready  in  1  from cache s_arready.
- busy  out  1  a transaction is held internally.

Behaviour:
- Reset:
  - m_arvalid=0, busy=0, corner=0; s_ready=1 once reset deasserts.
  - m_araddrx, m_araddry, m_aruser and m_arstrb are 0.
  - Reset mid-transaction discards all remaining beats; there is no partial flush.
- Accept:
  - A transaction is accepted on s_valid && s_ready.
  - The following are registered: x0 = s_x>>>FRAC_WIDTH (arithmetic floor, exact for negatives), y0 likewise, fracx/fracy = low FRAC_WIDTH bits, user.
  - x1 = x0+1 and y1 = y0+1, computed at X_INT_WIDTH+1 / Y_INT_WIDTH+1 bits so they never wrap.
  - param_* are sampled at accept and held for the whole transaction.
- Issue FSM, states IDLE and ISSUE, with a 2-bit corner counter:
  - IDLE -> ISSUE on accept, with m_arvalid=1 the next cycle. Latency from accept to the first beat is one cycle.
  - Corner order: 0=(x0,y0), 1=(x1,y0), 2=(x0,y1), 3=(x1,y1).
  - The corner advances on m_arvalid && m_arready. The last bit is 1 only on corner 3.
  - After corner 3 is handshaken: stay in ISSUE if a new transaction is accepted in the same cycle, otherwise go to IDLE.
- s_ready = IDLE || (corner==3 && m_arready). This allows back-to-back transactions with no bubble, giving 4 beats per transaction at steady state.
- AXI-style hold rules:
  - While m_arvalid=1 && m_arready=0, every m_* output is held stable.
  - m_arvalid never drops without a handshake.
- Per-corner bound check, done with signed compare on the extended coordinates:
  - A coordinate is in range when 0 <= c < param_size.
  - Blank mode: if either axis of a corner is out of range, arstrb=0 and the address is 0.
  - Clamp mode: c<0 maps to 0; c>=size maps to size-1; arstrb=1.
  - param_width=0 or param_height=0: every corner has arstrb=0 in both modes.
- busy = (state==ISSUE).

Optional Feature:
- Macro: JELLY2_TEXTURE_BILINEAR_SKIP_ZERO_EN.
- Defined:
  - fracx==0 skips corners 1 and 3; fracy==0 skips corners 2 and 3.
  - last is asserted on the final issued corner, so a transaction issues 1, 2 or 4 beats.
  - s_ready follows "final issued corner" instead of corner==3.
  - The corner field still reports the true corner index.
- Undefined: always 4 beats, exactly as described above.

Test Plan:
- Basic corners: x=0x00028 (2.5), y=0x00018 (1.5), width=height=16, m_arready=1 -> beats (2,1),(3,1),(2,2),(3,2); strb=1 on all; fracx=8, fracy=8; last only on beat 4; s_ready low for 3 cycles.
- Negative, blank mode: x=-0x8 (-0.5), y=0x10 (1.0), clamp=0 -> x0=-1, x1=0; corners 0 and 2 give strb=0 with addr 0; corners 1 and 3 give strb=1 at (0,1) and (0,2).
- Same coordinate, clamp=1 -> corners 0 and 2 give addrx=0 with strb=1; far edge x=15.5 with width=16 gives corner 1 addrx=15.
- Backpressure: m_arready toggles 1,0,0,1 on corner 1 -> outputs stable during the stall; exactly 4 handshakes; user echoed unchanged.
- Back-to-back: 3 transactions with s_valid held high -> 12 consecutive handshake cycles with no bubble; corner sequence 0..3 repeating; reset asserted on beat 6 -> m_arvalid=0 on the next cycle and busy=0.
- With JELLY2_TEXTURE_BILINEAR_SKIP_ZERO_EN: x=3.0, y=2.5 -> 2 beats, corners 0 and 2, last on corner 2; x=3.0, y=2.0 -> 1 beat, corner 0, with last set.
